// File: rtl/conv_window_addr_gen.sv
// Window read-address generator for strided KxK convolution over a raster image buffer.
// Optional zero-padding border is built when CONV_PAD_EN is defined.
module conv_window_addr_gen #(
  parameter int IMG_W  = 9,
  parameter int IMG_H  = 9,
  parameter int KERNEL = 3,
  parameter int STRIDE = 2,
  parameter int ADDR_W = $clog2(IMG_W*IMG_H)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              new_image_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic              rd_valid_o,
  input  logic              rd_ready_i,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic              rd_first_o,
  output logic              rd_last_o,
  output logic              rd_pad_o,
  output logic              done_o
);

  // state  | meaning
  // S_IDLE | one cycle after reset, clears counters
  // S_RUN  | accepting pixels and issuing window taps
  // S_DONE | final tap handed off, waiting for new_image
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam int N = IMG_W*IMG_H;
`ifdef CONV_PAD_EN
  localparam int P = KERNEL/2;
`else
  localparam int P = 0;
`endif
  localparam int OUT_W = (IMG_W + 2*P - KERNEL)/STRIDE + 1;
  localparam int OUT_H = (IMG_H + 2*P - KERNEL)/STRIDE + 1;
  localparam int CW    = ADDR_W + 2;
  localparam int WCW   = ADDR_W + 1;

  typedef logic [CW-1:0] cw_t;
  localparam cw_t IMG_W_C = cw_t'(IMG_W);
  localparam cw_t S_C     = cw_t'(STRIDE);
  localparam cw_t P_C     = cw_t'(P);
  localparam cw_t K1_C    = cw_t'(KERNEL-1);
  localparam cw_t OW1_C   = cw_t'(OUT_W-1);
  localparam cw_t OH1_C   = cw_t'(OUT_H-1);
  localparam logic [WCW-1:0] N_C = WCW'(N);
`ifdef CONV_PAD_EN
  localparam cw_t IMG_H_C = cw_t'(IMG_H);
`endif

  state_t            state_q, state_d;
  logic [WCW-1:0]    wr_cnt_q, wr_cnt_d;
  cw_t               ox_q, ox_d, oy_q, oy_d, kx_q, kx_d, ky_q, ky_d;
  logic              hn_q, hn_d;
  logic              rv_q, rv_d;
  logic [ADDR_W-1:0] ra_q, ra_d;
  logic              rf_q, rf_d, rl_q, rl_d, rp_q, rp_d;
  logic              done_q, done_d;

  cw_t  row, col, lin;
  logic tap_pad, tap_ok, wr_fire, rd_hs, load, final_tap;

  // Counters point at the next tap to load, so a handshake can refill in the same cycle.
  always_comb begin
    row = oy_q*S_C + ky_q - P_C;
    col = ox_q*S_C + kx_q - P_C;
    lin = row*IMG_W_C + col;
`ifdef CONV_PAD_EN
    tap_pad = row[CW-1] || col[CW-1] || (row >= IMG_H_C) || (col >= IMG_W_C);
`else
    tap_pad = 1'b0;
`endif
    tap_ok = tap_pad || (lin < cw_t'(wr_cnt_q));
  end

  assign in_ready_o = ((state_q == S_RUN) || (state_q == S_DONE)) &&
                      (wr_cnt_q < N_C) && !new_image_i;
  assign wr_fire    = in_ready_o && in_valid_i;
  assign rd_hs      = rv_q && rd_ready_i;
  assign load       = hn_q && tap_ok && (!rv_q || rd_ready_i);
  assign final_tap  = (kx_q == K1_C) && (ky_q == K1_C) && (ox_q == OW1_C) && (oy_q == OH1_C);

  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    ox_d     = ox_q;
    oy_d     = oy_q;
    kx_d     = kx_q;
    ky_d     = ky_q;
    hn_d     = hn_q;
    rv_d     = rv_q;
    ra_d     = ra_q;
    rf_d     = rf_q;
    rl_d     = rl_q;
    rp_d     = rp_q;
    done_d   = 1'b0;
    if (new_image_i || (state_q == S_IDLE)) begin
      state_d  = S_RUN;
      wr_cnt_d = '0;
      ox_d     = '0;
      oy_d     = '0;
      kx_d     = '0;
      ky_d     = '0;
      hn_d     = 1'b1;
      rv_d     = 1'b0;
      ra_d     = '0;
      rf_d     = 1'b0;
      rl_d     = 1'b0;
      rp_d     = 1'b0;
    end else begin
      if (wr_fire) wr_cnt_d = wr_cnt_q + WCW'(1);
      if (state_q == S_RUN) begin
        if (rd_hs && !hn_q) begin
          rv_d    = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (load) begin
          rv_d = 1'b1;
          ra_d = tap_pad ? '0 : lin[ADDR_W-1:0];
          rf_d = (kx_q == '0) && (ky_q == '0);
          rl_d = (kx_q == K1_C) && (ky_q == K1_C);
          rp_d = tap_pad;
          if (final_tap) hn_d = 1'b0;
          if (kx_q != K1_C) begin
            kx_d = kx_q + cw_t'(1);
          end else begin
            kx_d = '0;
            if (ky_q != K1_C) begin
              ky_d = ky_q + cw_t'(1);
            end else begin
              ky_d = '0;
              if (ox_q != OW1_C) begin
                ox_d = ox_q + cw_t'(1);
              end else begin
                ox_d = '0;
                oy_d = (oy_q != OH1_C) ? oy_q + cw_t'(1) : '0;
              end
            end
          end
        end else if (rd_hs) begin
          rv_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      wr_cnt_q <= '0;
      ox_q     <= '0;
      oy_q     <= '0;
      kx_q     <= '0;
      ky_q     <= '0;
      hn_q     <= 1'b0;
      rv_q     <= 1'b0;
      ra_q     <= '0;
      rf_q     <= 1'b0;
      rl_q     <= 1'b0;
      rp_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      ox_q     <= ox_d;
      oy_q     <= oy_d;
      kx_q     <= kx_d;
      ky_q     <= ky_d;
      hn_q     <= hn_d;
      rv_q     <= rv_d;
      ra_q     <= ra_d;
      rf_q     <= rf_d;
      rl_q     <= rl_d;
      rp_q     <= rp_d;
      done_q   <= done_d;
    end
  end

  assign wr_addr_o  = wr_cnt_q[ADDR_W-1:0];
  assign rd_valid_o = rv_q;
  assign rd_addr_o  = ra_q;
  assign rd_first_o = rf_q;
  assign rd_last_o  = rl_q;
  assign rd_pad_o   = rp_q;
  assign done_o     = done_q;

endmodule
